// File: rtl/mul4_share_arbiter_if.sv
// rtl/mul4_share_arbiter_if.sv - requester and response bus for the shared 4x4 multiplier
//
// Purpose: groups the request (valid/operands/ready) and response
// (valid/ready/id/product) handshakes of mul4_share_arbiter.
// Ports (signals):
//   req_valid [NREQ]   requester strobes
//   req_a/req_b [4*NREQ] operand pairs, requester i at [4i+3:4i]
//   req_ready [NREQ]   one-hot grant
//   rsp_valid/rsp_ready response handshake
//   rsp_id [3], rsp_p [8] owner and product
// Modports: master = requester/consumer side, slave = arbiter side.

interface mul4_share_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [2:0]        rsp_id;
  logic [7:0]        rsp_p;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p
  );
endinterface

// File: rtl/mul4_share_arbiter.sv
// rtl/mul4_share_arbiter.sv - round-robin sharing controller for one combinational 4x4 multiplier
//
// Purpose: grants one of NREQ requesters at a time, registers its operands
// into the external multiplier, captures the product after one EVAL cycle
// and returns it with the requester id over a valid/ready response.
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   bus (slave)   request and response handshakes
//   mul_a, mul_b  registered operands to the multiplier
//   mul_p         product from the multiplier
//   busy          high outside IDLE
//   txn_cnt       completed responses, wraps at 256

module mul4_share_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  mul4_share_arbiter_if.slave        bus,
  output logic [3:0]                 mul_a,
  output logic [3:0]                 mul_b,
  input  logic [7:0]                 mul_p,
  output logic                       busy,
  output logic [7:0]                 txn_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] op_a_q, op_a_d;
  logic [3:0] op_b_q, op_b_d;
  logic [2:0] id_q, id_d;
  logic [7:0] res_q, res_d;
  logic [7:0] txn_cnt_q, txn_cnt_d;

  logic [NREQ-1:0] grant;
  logic            gnt_found;
  logic [2:0]      gnt_idx;
  logic [3:0]      cand;

  // Round-robin search: candidate k is (ptr + k) mod NREQ; first valid wins.
  // Only evaluated in IDLE and never while rst is high.
  always_comb begin
    grant     = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    if (state_q == IDLE && !rst) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = {1'b0, ptr_q} + 4'(k);
        if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
        for (int j = 0; j < NREQ; j++) begin
          if (!gnt_found && cand == 4'(j) && bus.req_valid[j]) begin
            gnt_found = 1'b1;
            gnt_idx   = 3'(j);
          end
        end
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (gnt_found && gnt_idx == 3'(j)) grant[j] = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    id_d      = id_q;
    res_d     = res_q;
    txn_cnt_d = txn_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          for (int j = 0; j < NREQ; j++) begin
            if (gnt_idx == 3'(j)) begin
              op_a_d = bus.req_a[4*j +: 4];
              op_b_d = bus.req_b[4*j +: 4];
            end
          end
          id_d    = gnt_idx;
          ptr_d   = (gnt_idx == 3'(NREQ-1)) ? 3'd0 : gnt_idx + 3'd1;
          state_d = EVAL;
        end
      end
      EVAL: begin
        // Operands have been stable on mul_a/mul_b since the grant edge.
        res_d   = mul_p;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          txn_cnt_d = txn_cnt_q + 8'd1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      id_q      <= '0;
      res_q     <= '0;
      txn_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      id_q      <= id_d;
      res_q     <= res_d;
      txn_cnt_q <= txn_cnt_d;
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_p     = res_q;
  assign mul_a         = op_a_q;
  assign mul_b         = op_b_q;
  assign busy          = (state_q != IDLE);
  assign txn_cnt       = txn_cnt_q;

endmodule

// File: tb/tb_mul4_share_arbiter.sv
// tb/tb_mul4_share_arbiter.sv - directed self-checking bench for mul4_share_arbiter

module tb_mul4_share_arbiter;
  localparam int NREQ = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] mul_a, mul_b;
  logic [7:0] mul_p;
  logic       busy;
  logic [7:0] txn_cnt;

  int n_checks = 0;
  int n_errors = 0;

  mul4_share_arbiter_if #(.NREQ(NREQ)) bus ();

  mul4_share_arbiter #(.NREQ(NREQ)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .mul_p   (mul_p),
    .busy    (busy),
    .txn_cnt (txn_cnt)
  );

  // Stand-in for the external combinational multiplier.
  assign mul_p = {4'b0, mul_a} * {4'b0, mul_b};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int idx, input logic [3:0] a, input logic [3:0] b);
    bus.req_a[4*idx +: 4] = a;
    bus.req_b[4*idx +: 4] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    step();
    rst = 1'b0;
    #1;
  endtask

  // One full transaction with rsp_ready held high: grant, EVAL, RESP, handshake.
  task automatic run_txn(input int idx, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] exp_p);
    set_op(idx, a, b);
    bus.req_valid = 4'b0001 << idx;
    #1;
    check("txn_grant", bus.req_ready, 4'b0001 << idx);
    step();
    bus.req_valid = '0;
    check("txn_eval_nvalid", bus.rsp_valid, 1'b0);
    step();
    check("txn_rsp_valid", bus.rsp_valid, 1'b1);
    check("txn_rsp_p", bus.rsp_p, exp_p);
    check("txn_rsp_id", bus.rsp_id, idx);
    step();
  endtask

  initial begin
    int gcyc[$];
    logic [NREQ-1:0] gval[$];
    logic [3:0] exp_grants [5];

    rst = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;

    // Reset state, with requests present that must not be granted.
    step();
    check("rst_req_ready", bus.req_ready, 4'b0000);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_txn_cnt", txn_cnt, 8'd0);
    check("rst_mul_a", mul_a, 4'd0);
    bus.req_valid = '0;
    rst = 1'b0;
    #1;

    // Single request: requester 0, 3*5.
    set_op(0, 4'd3, 4'd5);
    bus.req_valid = 4'b0001;
    #1;
    check("single_grant", bus.req_ready, 4'b0001);
    step();
    bus.req_valid = '0;
    check("single_busy", busy, 1'b1);
    check("single_eval_ready", bus.req_ready, 4'b0000);
    check("single_mul_a", mul_a, 4'd3);
    check("single_mul_b", mul_b, 4'd5);
    check("single_eval_nvalid", bus.rsp_valid, 1'b0);
    step();
    check("single_rsp_valid", bus.rsp_valid, 1'b1);
    check("single_rsp_p", bus.rsp_p, 8'd15);
    check("single_rsp_id", bus.rsp_id, 3'd0);
    step();
    check("single_txn_cnt", txn_cnt, 8'd1);
    check("single_idle", busy, 1'b0);

    // Exhaustive arithmetic on requester 2; 256 transactions also wrap txn_cnt.
    do_reset();
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_txn(2, 4'(a), 4'(b), 8'(a * b));
        if (a == 15 && b == 14) check("wrap_pre", txn_cnt, 8'd255);
      end
    end
    check("wrap_zero", txn_cnt, 8'd0);

    // Round-robin with all four requesting.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 4'(i + 1), 4'd2);
    bus.req_valid = 4'b1111;
    #1;
    for (int c = 0; c < 15; c++) begin
      if (bus.req_ready != '0) begin
        gcyc.push_back(c);
        gval.push_back(bus.req_ready);
      end
      step();
    end
    bus.req_valid = '0;
    exp_grants[0] = 4'b0001;
    exp_grants[1] = 4'b0010;
    exp_grants[2] = 4'b0100;
    exp_grants[3] = 4'b1000;
    exp_grants[4] = 4'b0001;
    check("rr_count", gcyc.size(), 5);
    for (int i = 0; i < 5 && i < gcyc.size(); i++) begin
      check("rr_order", gval[i], exp_grants[i]);
      check("rr_cycle", gcyc[i], 3 * i);
    end

    // Backpressure: hold RESP for 5 cycles while requester 1 waits.
    do_reset();
    bus.rsp_ready = 1'b0;
    set_op(0, 4'd7, 4'd9);
    set_op(1, 4'd2, 4'd3);
    bus.req_valid = 4'b0001;
    #1;
    check("bp_grant0", bus.req_ready, 4'b0001);
    step();
    bus.req_valid = 4'b0010;
    #1;
    check("bp_eval_ready", bus.req_ready, 4'b0000);
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", bus.rsp_valid, 1'b1);
      check("bp_rsp_p", bus.rsp_p, 8'd63);
      check("bp_req_ready", bus.req_ready, 4'b0000);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_hs_valid", bus.rsp_valid, 1'b1);
    check("bp_hs_ready", bus.req_ready, 4'b0000);
    step();
    check("bp_grant1", bus.req_ready, 4'b0010);
    step();
    bus.req_valid = '0;
    step();
    check("bp_rsp1_p", bus.rsp_p, 8'd6);
    check("bp_rsp1_id", bus.rsp_id, 3'd1);
    step();
    check("bp_txn_cnt", txn_cnt, 8'd2);

    // Reset during EVAL: aborted response, ptr back to 0, txn_cnt cleared.
    set_op(2, 4'd4, 4'd4);
    bus.req_valid = 4'b0100;
    #1;
    check("ab_grant2", bus.req_ready, 4'b0100);
    step();
    check("ab_in_eval", busy, 1'b1);
    rst = 1'b1;
    bus.req_valid = '0;
    step();
    rst = 1'b0;
    #1;
    check("ab_txn_cnt", txn_cnt, 8'd0);
    check("ab_busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("ab_no_rsp", bus.rsp_valid, 1'b0);
      step();
    end
    set_op(1, 4'd6, 4'd5);
    bus.req_valid = 4'b1110;
    #1;
    check("ab_grant1", bus.req_ready, 4'b0010);
    step();
    bus.req_valid = '0;
    step();
    check("ab_rsp_p", bus.rsp_p, 8'd30);
    step();
    check("ab_txn_after", txn_cnt, 8'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
